// File: rtl/blit_pkg.sv
// blit_pkg: shared mode/state types and default screen constants for the sprite blitter.
package blit_pkg;
  localparam int DEF_SCREEN_W = 320;
  localparam int DEF_SCREEN_H = 240;
  localparam int DEF_COLOUR_W = 6;
  localparam logic [DEF_COLOUR_W-1:0] DEF_KEY_COLOUR = '1;
  typedef enum logic [1:0] {MODE_DRAW = 2'd0, MODE_ERASE = 2'd1, MODE_FILL = 2'd2} mode_e;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_EMIT, S_DONE} state_e;
endpackage

// File: rtl/blit_addr_gen.sv
// blit_addr_gen: raster col/row counters, sprite/background addresses and screen clip flag.
module blit_addr_gen import blit_pkg::*; #(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int X_W = 9,
  parameter int Y_W = 8,
  parameter int DIM_W = 6,
  parameter int SPR_ADDR_W = 15,
  parameter int BG_ADDR_W = 17
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  init,
  input  logic                  step,
  input  logic [SPR_ADDR_W-1:0] sprite_base,
  input  logic [X_W-1:0]        x_start,
  input  logic [Y_W-1:0]        y_start,
  input  logic [DIM_W-1:0]      width,
  input  logic [DIM_W-1:0]      height,
  output logic [SPR_ADDR_W-1:0] spr_addr,
  output logic [BG_ADDR_W-1:0]  bg_addr,
  output logic [X_W-1:0]        pix_x,
  output logic [Y_W-1:0]        pix_y,
  output logic                  clip,
  output logic                  last
);
  logic [DIM_W-1:0] col_q, col_d, row_q, row_d;
  logic [X_W:0] px;
  logic [Y_W:0] py;
  logic row_end;
  // One extra bit on the screen sums so off-screen coordinates never wrap back on.
  always_comb begin
    px = (X_W+1)'(x_start) + (X_W+1)'(col_q);
    py = (Y_W+1)'(y_start) + (Y_W+1)'(row_q);
    row_end = col_q == width - DIM_W'(1);
    last = row_end && row_q == height - DIM_W'(1);
    clip = px >= (X_W+1)'(SCREEN_W) || py >= (Y_W+1)'(SCREEN_H);
    pix_x = px[X_W-1:0];
    pix_y = py[Y_W-1:0];
    spr_addr = sprite_base + SPR_ADDR_W'(row_q) * SPR_ADDR_W'(width) + SPR_ADDR_W'(col_q);
    bg_addr = BG_ADDR_W'(py) * BG_ADDR_W'(SCREEN_W) + BG_ADDR_W'(px);
    col_d = init ? '0 : step ? (row_end ? '0 : col_q + DIM_W'(1)) : col_q;
    row_d = init ? '0 : step && row_end ? row_q + DIM_W'(1) : row_q;
  end
  always_ff @(posedge clock) begin
    if (!resetn) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end
endmodule

// File: rtl/sprite_blitter.sv
// sprite_blitter: DRAW/ERASE/FILL rectangular blit with transparency key and screen clipping.
// Defining BLIT_COLLIDE_EN adds a DRAW-mode collision counter on collide_count.
module sprite_blitter import blit_pkg::*; #(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int X_W = 9,
  parameter int Y_W = 8,
  parameter int COLOUR_W = 6,
  parameter int MAX_W = 32,
  parameter int MAX_H = 32,
  parameter int SPR_ADDR_W = 15,
  parameter int BG_ADDR_W = 17,
  parameter int MEM_LAT = 1,
  parameter logic [COLOUR_W-1:0] KEY_COLOUR = '1,
  localparam int DIM_W = $clog2((MAX_W > MAX_H ? MAX_W : MAX_H) + 1)
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [SPR_ADDR_W-1:0] sprite_base,
  input  logic [X_W-1:0]        x_start,
  input  logic [Y_W-1:0]        y_start,
  input  logic [DIM_W-1:0]      width,
  input  logic [DIM_W-1:0]      height,
  input  logic [COLOUR_W-1:0]   fill_colour,
  output logic [SPR_ADDR_W-1:0] spr_addr,
  input  logic [COLOUR_W-1:0]   spr_data,
  output logic [BG_ADDR_W-1:0]  bg_addr,
  input  logic [COLOUR_W-1:0]   bg_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic [X_W-1:0]        pix_x,
  output logic [Y_W-1:0]        pix_y,
  output logic [COLOUR_W-1:0]   pix_colour,
  output logic                  busy,
  output logic                  done,
  output logic [2*DIM_W-1:0]    collide_count
);
  localparam int LAT_W = $clog2(MEM_LAT + 1);
  state_e state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic [SPR_ADDR_W-1:0] base_q, base_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [DIM_W-1:0] w_q, w_d, h_q, h_d;
  logic [COLOUR_W-1:0] fill_q, fill_d, colour_q, colour_d, mem_colour;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic init, step, clip, last, data_ok;
  blit_addr_gen #(
    .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .X_W(X_W), .Y_W(Y_W),
    .DIM_W(DIM_W), .SPR_ADDR_W(SPR_ADDR_W), .BG_ADDR_W(BG_ADDR_W)
  ) u_addr (
    .clock(clock), .resetn(resetn), .init(init), .step(step),
    .sprite_base(base_q), .x_start(x_q), .y_start(y_q), .width(w_q), .height(h_q),
    .spr_addr(spr_addr), .bg_addr(bg_addr), .pix_x(pix_x), .pix_y(pix_y),
    .clip(clip), .last(last)
  );
  assign mem_colour = mode_q == MODE_DRAW ? (spr_data == KEY_COLOUR ? bg_data : spr_data) :
                      mode_q == MODE_ERASE ? bg_data : fill_q;
  assign data_ok = lat_q == LAT_W'(MEM_LAT - 1);
  assign pix_valid = state_q == S_EMIT;
  assign busy = state_q inside {S_FETCH, S_WAIT, S_EMIT};
  assign done = state_q == S_DONE;
  assign pix_colour = colour_q;
  always_comb begin
    state_d = state_q;
    {mode_d, base_d, x_d, y_d, w_d, h_d, fill_d} = {mode_q, base_q, x_q, y_q, w_q, h_q, fill_q};
    colour_d = colour_q;
    lat_d = lat_q;
    init = 1'b0;
    step = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        init = 1'b1;
        {mode_d, base_d, x_d, y_d, w_d, h_d, fill_d} = {mode, sprite_base, x_start, y_start, width, height, fill_colour};
        state_d = width == '0 || height == '0 ? S_DONE : S_FETCH;
      end
      // Clipped pixels skip the memory wait and emit, costing one FETCH cycle each.
      S_FETCH: begin
        lat_d = '0;
        step = clip;
        state_d = !clip ? S_WAIT : last ? S_DONE : S_FETCH;
      end
      S_WAIT: begin
        lat_d = lat_q + LAT_W'(1);
        if (data_ok) begin
          colour_d = mem_colour;
          state_d = S_EMIT;
        end
      end
      S_EMIT: if (pix_ready) begin
        step = 1'b1;
        state_d = last ? S_DONE : S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      {mode_q, base_q, x_q, y_q, w_q, h_q, fill_q} <= '0;
      colour_q <= '0;
      lat_q <= '0;
    end else begin
      state_q <= state_d;
      {mode_q, base_q, x_q, y_q, w_q, h_q, fill_q} <= {mode_d, base_d, x_d, y_d, w_d, h_d, fill_d};
      colour_q <= colour_d;
      lat_q <= lat_d;
    end
  end
`ifdef BLIT_COLLIDE_EN
  logic [2*DIM_W-1:0] hits_q, hits_d;
  always_comb begin
    hits_d = state_q == S_IDLE && start ? '0 :
             state_q == S_WAIT && data_ok && mode_q == MODE_DRAW && bg_data != KEY_COLOUR && bg_data != '0 ?
             hits_q + (2*DIM_W)'(1) : hits_q;
  end
  always_ff @(posedge clock) begin
    if (!resetn) hits_q <= '0;
    else hits_q <= hits_d;
  end
  assign collide_count = hits_q;
`else
  assign collide_count = '0;
`endif
endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: directed and randomized blits checked against a raster-loop reference model.
module tb_sprite_blitter;
  localparam int SW = 320, SH = 240, KEY = 63;
  logic clock = 1'b0, resetn = 1'b0, start = 1'b0, pix_ready = 1'b0;
  logic [1:0] mode = '0;
  logic [14:0] sprite_base = '0;
  logic [8:0] x_start = '0;
  logic [7:0] y_start = '0;
  logic [5:0] width = '0, height = '0, fill_colour = '0;
  logic [14:0] spr_addr;
  logic [16:0] bg_addr;
  logic [5:0] spr_data, bg_data, pix_colour;
  logic pix_valid, busy, done;
  logic [8:0] pix_x;
  logic [7:0] pix_y;
  logic [11:0] collide_count;
  logic [5:0] rom [0:32767];
  logic [5:0] bgm [0:131071];
  typedef struct { int x; int y; int c; int sa; int ba; } pix_t;
  pix_t exp_q[$];
  pix_t log_q[$];
  int cyc = 0, n_cmp = 0, n_err = 0;
  int exp_col, s_cyc, f_cyc, d_cyc, last_hs, hs_cnt, v_cnt;

  sprite_blitter dut (
    .clock(clock), .resetn(resetn), .start(start), .mode(mode), .sprite_base(sprite_base),
    .x_start(x_start), .y_start(y_start), .width(width), .height(height), .fill_colour(fill_colour),
    .spr_addr(spr_addr), .spr_data(spr_data), .bg_addr(bg_addr), .bg_data(bg_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
    .pix_colour(pix_colour), .busy(busy), .done(done), .collide_count(collide_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) begin
    spr_data <= rom[spr_addr];
    bg_data <= bgm[bg_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 32'(pix_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_spr_addr"}, 32'(spr_addr), 0);
    chk({tag, "_bg_addr"}, 32'(bg_addr), 0);
    chk({tag, "_x"}, 32'(pix_x), 0);
    chk({tag, "_y"}, 32'(pix_y), 0);
    chk({tag, "_colour"}, 32'(pix_colour), 0);
    chk({tag, "_collide"}, 32'(collide_count), 0);
  endtask

  // Reference: walk the footprint in raster order, drop off-screen pixels, pick colour by mode.
  task automatic build(input int m, input int base, input int x, input int y, input int w, input int h, input int fill);
    exp_q.delete();
    exp_col = 0;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        pix_t p;
        int s, b;
        if (x + c >= SW || y + r >= SH) continue;
        p.x = x + c;
        p.y = y + r;
        p.sa = (base + r * w + c) % 32768;
        p.ba = (y + r) * SW + x + c;
        s = int'(rom[p.sa]);
        b = int'(bgm[p.ba]);
        p.c = m == 0 ? (s == KEY ? b : s) : m == 1 ? b : fill;
        if (m == 0 && b != KEY && b != 0) exp_col++;
        exp_q.push_back(p);
      end
  endtask

  task automatic run_blit(input int m, input int base, input int x, input int y, input int w, input int h,
                          input int fill, input int pct, input int stall, input int restart_at, input int rst_hs);
    int lim, stl;
    bit got, aborted, tail_in;
    build(m, base, x, y, w, h, fill);
    log_q.delete();
    hs_cnt = 0; v_cnt = 0; f_cyc = -1; last_hs = -1; d_cyc = -1; stl = stall;
    lim = 100 + w * h * 60;
    tail_in = (x + w - 1 < SW) && (y + h - 1 < SH);
    @(posedge clock); #1;
    mode = 2'(m); sprite_base = 15'(base); x_start = 9'(x); y_start = 8'(y);
    width = 6'(w); height = 6'(h); fill_colour = 6'(fill); start = 1'b1;
    s_cyc = cyc;
    @(posedge clock); #1;
    mode = 2'($urandom); sprite_base = 15'($urandom); x_start = 9'($urandom); y_start = 8'($urandom);
    width = 6'($urandom); height = 6'($urandom); fill_colour = 6'($urandom);
    got = 1'b0; aborted = 1'b0;
    for (int i = 0; i < lim && !got && !aborted; i++) begin
      start = (i == restart_at);
      if (pix_valid && stl > 0) begin
        pix_ready = 1'b0;
        stl--;
      end else pix_ready = $urandom_range(99) < pct;
      if (rst_hs > 0 && hs_cnt == rst_hs) begin
        resetn = 1'b0;
        pix_ready = 1'b0;
        aborted = 1'b1;
      end
      @(negedge clock);
      if (pix_valid) begin
        v_cnt++;
        if (f_cyc < 0) f_cyc = cyc;
        if (exp_q.size() == 0) chk("extra_pixel", 1, 0);
        else begin
          chk("pix_x", 32'(pix_x), exp_q[0].x);
          chk("pix_y", 32'(pix_y), exp_q[0].y);
          chk("pix_colour", 32'(pix_colour), exp_q[0].c);
          chk("spr_addr", 32'(spr_addr), exp_q[0].sa);
          chk("bg_addr", 32'(bg_addr), exp_q[0].ba);
          if (pix_ready) begin
            pix_t a;
            a.x = int'(pix_x); a.y = int'(pix_y); a.c = int'(pix_colour);
            a.sa = int'(spr_addr); a.ba = int'(bg_addr);
            log_q.push_back(a);
            void'(exp_q.pop_front());
            hs_cnt++;
            last_hs = cyc;
          end
        end
      end
      got = done;
      if (got) d_cyc = cyc;
      if (aborted) chk("done_abort", 32'(done), 0);
      else if (!got) begin
        chk("busy", 32'(busy), 1);
        @(posedge clock); #1;
      end
    end
    start = 1'b0;
    if (aborted) begin
      @(posedge clock); #1;
      resetn = 1'b1;
      @(negedge clock);
      check_zero("abort");
      repeat (3) begin
        @(negedge clock);
        chk("no_done_after_abort", 32'(done), 0);
      end
      exp_q.delete();
    end else if (!got) begin
      chk("done_timeout", 0, 1);
      @(posedge clock); #1;
      resetn = 1'b0;
      @(posedge clock); #1;
      resetn = 1'b1;
    end else begin
      chk("pixels_left", exp_q.size(), 0);
      chk("busy_at_done", 32'(busy), 0);
      chk("valid_at_done", 32'(pix_valid), 0);
      if (hs_cnt > 0 && tail_in) chk("done_delay", d_cyc - last_hs, 1);
      if (w == 0 || h == 0) chk("zero_done_delay", d_cyc - s_cyc, 1);
`ifdef BLIT_COLLIDE_EN
      chk("collide", 32'(collide_count), exp_col);
`else
      chk("collide_tied", 32'(collide_count), 0);
`endif
      @(negedge clock);
      chk("done_pulse", 32'(done), 0);
    end
  endtask

  initial begin
    int ex[4], ey[4];
    for (int i = 0; i < 32768; i++) rom[i] = ($urandom_range(3) == 0) ? 6'h3F : 6'($urandom_range(62));
    for (int i = 0; i < 131072; i++)
      bgm[i] = ($urandom_range(4) == 0) ? 6'h00 : ($urandom_range(4) == 0) ? 6'h3F : 6'($urandom_range(1, 62));
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_zero("reset");
    @(posedge clock); #1;
    resetn = 1'b1;

    for (int i = 0; i < 8; i++) rom[100 + i] = 6'(i + 5);
    rom[101] = 6'h3F;
    bgm[6411] = 6'h2A;
    run_blit(0, 100, 10, 20, 4, 2, 0, 100, 0, -1, 0);
    chk("draw_count", hs_cnt, 8);
    chk("draw_latency", f_cyc - s_cyc, 3);
    if (log_q.size() == 8) begin
      chk("draw_p0_colour", log_q[0].c, 5);
      chk("draw_p1_x", log_q[1].x, 11);
      chk("draw_p1_colour", log_q[1].c, 42);
      chk("draw_p1_bg_addr", log_q[1].ba, 6411);
      chk("draw_p0_spr_addr", log_q[0].sa, 100);
      chk("draw_p7_spr_addr", log_q[7].sa, 107);
      chk("draw_p7_x", log_q[7].x, 13);
      chk("draw_p7_y", log_q[7].y, 21);
    end

    run_blit(2, 0, 318, 238, 3, 3, 21, 100, 0, -1, 0);
    chk("fill_count", hs_cnt, 4);
    ex = '{318, 319, 318, 319};
    ey = '{238, 238, 239, 239};
    if (log_q.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk("fill_x", log_q[i].x, ex[i]);
        chk("fill_y", log_q[i].y, ey[i]);
        chk("fill_colour", log_q[i].c, 21);
      end

    bgm[32100] = 6'h11;
    bgm[32101] = 6'h22;
    run_blit(1, 0, 100, 100, 2, 1, 0, 100, 5, -1, 0);
    chk("erase_count", hs_cnt, 2);
    chk("erase_valid_cycles", v_cnt, 7);
    if (log_q.size() == 2) begin
      chk("erase_p0_colour", log_q[0].c, 17);
      chk("erase_p1_colour", log_q[1].c, 34);
    end

    run_blit(0, 50, 40, 40, 0, 5, 0, 100, 0, -1, 0);
    chk("zero_count", hs_cnt, 0);
    chk("zero_valid", v_cnt, 0);

    run_blit(0, 500, 50, 50, 32, 32, 0, 100, 0, 10, 0);
    chk("big_count", hs_cnt, 1024);

    run_blit(0, 900, 30, 30, 4, 4, 0, 100, 0, -1, 4);
    chk("abort_hs", hs_cnt, 4);
    run_blit(1, 0, 60, 70, 3, 2, 0, 100, 0, -1, 0);
    chk("after_abort_count", hs_cnt, 6);

    bgm[100 * SW + 200] = 6'h00;
    bgm[100 * SW + 201] = 6'h3F;
    bgm[100 * SW + 202] = 6'h12;
    bgm[100 * SW + 203] = 6'h07;
    run_blit(0, 2000, 200, 100, 4, 1, 0, 100, 0, -1, 0);
`ifdef BLIT_COLLIDE_EN
    chk("collide_literal", 32'(collide_count), 2);
`else
    chk("collide_literal", 32'(collide_count), 0);
`endif

    for (int t = 0; t < 30; t++)
      run_blit($urandom_range(3), $urandom_range(32767), $urandom_range(340), $urandom_range(250),
               $urandom_range(10), $urandom_range(10), $urandom_range(63), $urandom_range(30, 100),
               0, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Parametrised rectangular blit engine for the VGA pixel writer: draws a runtime-sized sprite from sprite ROM, erases to background, or fills solid, at any (x,y).
- Generates sprite and background memory addresses, applies the transparency key, clips at screen edges, and emits one pixel per accepted valid/ready handshake.
- Sits between the game control FSM (start/done) and the framebuffer writer (pixel stream).

Parameters:
- SCREEN_W, 320: screen width in pixels.
- SCREEN_H, 240: screen height in pixels.
- X_W, 9: x coordinate width.
- Y_W, 8: y coordinate width.
- COLOUR_W, 6: pixel colour width.
- MAX_W, 32: maximum sprite width; DIM_W = clog2(MAX_W+1).
- MAX_H, 32: maximum sprite height, using the same DIM_W rule.
- SPR_ADDR_W, 15: sprite ROM address width.
- BG_ADDR_W, 17: background memory address width.
- MEM_LAT, 1: read latency of both memories in cycles (≥1).
- KEY_COLOUR, all-ones: transparent colour in sprite data.

Ports:
- clock  in  1  system clock.
- resetn  in  1  synchronous active-low reset.
- start  in  1  begin a blit; sampled only in IDLE.
- mode  in  2  0 DRAW, 1 ERASE, 2 FILL, 3 reserved (treated as FILL).
- sprite_base  in  SPR_ADDR_W  sprite ROM offset of the sprite's first pixel.
- x_start  in  X_W  top-left x.
- y_start  in  Y_W  top-left y.
- width  in  DIM_W  sprite width, 0..MAX_W.
- height  in  DIM_W  sprite height, 0..MAX_H.
- fill_colour  in  COLOUR_W  colour used in FILL mode.
- spr_addr  out  SPR_ADDR_W  sprite ROM read address.
- spr_data  in  COLOUR_W  sprite ROM data, MEM_LAT cycles after address.
- bg_addr  out  BG_ADDR_W  background memory read address.
- bg_data  in  COLOUR_W  background data, MEM_LAT cycles after address.
- pix_valid  out  1  pixel output valid.
- pix_ready  in  1  framebuffer writer accepts the pixel.
- pix_x  out  X_W  pixel x.
- pix_y  out  Y_W  pixel y.
- pix_colour  out  COLOUR_W  pixel colour.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at completion.
- collide_count  out  DIM_W*2  count of non-background pixels under the footprint (optional feature).

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters cleared. Reset mid-blit aborts immediately with no done pulse.
- Start capture: start in IDLE latches mode, sprite_base, x_start, y_start, width, height and fill_colour. Later changes to these inputs have no effect. start is ignored while busy.
- FSM states: IDLE → FETCH → WAIT (MEM_LAT cycles) → EMIT → FETCH or DONE → IDLE.
  - FETCH: spr_addr = sprite_base + row*width + col; bg_addr = (y_start+row)*SCREEN_W + x_start + col; raster column counter col and row counter row, col first.
  - EMIT: pix_valid held with stable pix_x/pix_y/pix_colour until pix_ready. The transfer completes on the cycle where pix_valid && pix_ready.
- Colour by mode:
  - DRAW: spr_data, or bg_data when spr_data == KEY_COLOUR.
  - ERASE: bg_data.
  - FILL: fill_colour.
- Clipping: a pixel with x_start+col ≥ SCREEN_W or y_start+row ≥ SCREEN_H is skipped with no EMIT and no memory read; the FSM goes straight to the next pixel. Sums use widths X_W+1 and Y_W+1, with no wrap.
- Wrap: col == width-1 sets col to 0 and increments row. The last pixel (row == height-1, col == width-1) → DONE.
- Zero size: width == 0 or height == 0 → DONE on the cycle after start, with no pixels.
- Throughput: minimum 2+MEM_LAT cycles per emitted pixel. Latency from start to first pix_valid = 2+MEM_LAT cycles.
- done asserts the cycle after the final handshake. busy drops in the same cycle.

Optional Feature:
- Macro: BLIT_COLLIDE_EN.
- Defined: in DRAW mode, every in-screen footprint pixel whose bg_data is not KEY_COLOUR and not 0 increments collide_count. The count clears on start and is valid from done until the next start.
- Undefined: collide_count is tied to 0 and the extra compare/counter logic is absent.

Decomposition:
- Package blit_pkg:
  - mode enum (MODE_DRAW, MODE_ERASE, MODE_FILL).
  - FSM state enum.
  - Default SCREEN_W/SCREEN_H and KEY_COLOUR constants.
- Sub-module blit_addr_gen:
  - Holds the col/row raster counters, both address computations and the clip flag.
  - Advances on a single step input and reports a last flag.
  - The top level keeps the FSM, latency pipe, colour select and handshake.

Test Plan:
- DRAW 4x2 at (10,20), sprite_base=100, ROM pixel (1,0)=KEY_COLOUR, pix_ready=1 → 8 pixels in raster order (10,20)…(13,21); pixel (11,20) carries bg_data from bg_addr 6411; spr_addr sequence 100..107; done 1 cycle after the 8th handshake.
- FILL 3x3 at (318,238), fill_colour=0x15 → only (318,238), (319,238), (318,239), (319,239) emitted, all 0x15; done asserted.
- ERASE 2x1 with pix_ready low for 5 cycles on the first pixel → pix_valid/x/y/colour stable for all 5 cycles; exactly 2 transfers.
- width=0, start → done on the next cycle, no pix_valid; a start during busy of a 32x32 blit → ignored, still 1024 pixels.
- resetn low mid-blit (pixel 5 of 16) → outputs 0 next cycle, no done; a new blit afterwards completes normally.
- BLIT_COLLIDE_EN: DRAW 4x1 over bg {0, 0x3F, 0x12, 0x07} → collide_count=2.
